data_mem_responder: RTL and testbench

Synthesizable data-memory responder for the core's load/store port. It answers the core's request/grant/valid data-bus protocol: accepts one transaction at a time, performs byte-enabled writes or word reads on an internal word array, and returns the response after a programmable latency. It sits between the core's data interface and the bench top level. It is also the reference memory for the system-level store/load tests.

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-outstanding data-bus responder: byte-enabled stores and word loads on an
// internal word array, answering with a one-cycle rvalid strobe LATENCY cycles after grant.
module data_mem_responder #(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int DATA_WORD_WIDTH = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       data_req_i,
  output logic                       data_gnt_o,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                       data_we_i,
  input  logic [3:0]                 data_be_i,
  input  logic [DATA_WORD_WIDTH-1:0] data_wdata_i,
  output logic                       data_rvalid_o,
  output logic [DATA_WORD_WIDTH-1:0] data_rdata_o,
  output logic                       data_err_o
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = DATA_WORD_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [3:0]                 cnt_reg, cnt_next;
  logic                       we_reg;
  logic                       err_reg;
  logic [DATA_WORD_WIDTH-1:0] rword_reg;
  logic [DATA_WORD_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                       accept;
  logic                       misaligned;
  logic                       out_of_range;
  logic                       addr_err;
  logic                       mem_we;
  logic [IDX_W-1:0]           word_idx;
  logic [NUM_LANES-1:0]       lane_we;

  // Any set bit above the word-index field puts the address past the array.
  generate
    if (DATA_ADDR_WIDTH > IDX_W + 2) begin : g_range
      assign out_of_range = |data_addr_i[DATA_ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign misaligned = |data_addr_i[1:0];
  assign addr_err   = misaligned | out_of_range;
  assign word_idx   = data_addr_i[IDX_W+1:2];

  assign data_gnt_o = (state_reg == IDLE) & data_req_i & ~rst_i;
  assign accept     = data_gnt_o;
  assign mem_we     = accept & data_we_i & ~addr_err;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_we[gi] = mem_we & data_be_i[gi];
  end

  // Byte-lane write plus registered read; a load never writes, so no same-edge conflict.
  always_ff @(posedge clk_i) begin
    for (int li = 0; li < NUM_LANES; li++) begin
      if (lane_we[li]) begin
        mem[word_idx][8*li +: 8] <= data_wdata_i[8*li +: 8];
      end
    end
    if (accept) begin
      rword_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg  <= data_we_i;
        err_reg <= addr_err;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Response fields come only from registers and are forced to zero outside RESP.
  assign data_rvalid_o = (state_reg == RESP);
  assign data_err_o    = (state_reg == RESP) & err_reg;
  assign data_rdata_o  = ((state_reg == RESP) && !we_reg && !err_reg) ? rword_reg : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (latency 1, 3, 4) checked every cycle against a transaction-level
// model, plus directed transactions with literal expected values.
module tb_data_mem_responder;

  localparam int NI          = 3;
  localparam int DEPTH       = 256;
  localparam int RAND_CYCLES = 900;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst, req, we, gnt, rvalid, err;
  logic [NI-1:0][31:0] addr, wdata, rdata;
  logic [NI-1:0][3:0]  be;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    data_mem_responder #(
      .DATA_ADDR_WIDTH(32),
      .DATA_WORD_WIDTH(32),
      .DEPTH_WORDS    (DEPTH),
      .LATENCY        (lat_of(gi))
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst[gi]),
      .data_req_i   (req[gi]),
      .data_gnt_o   (gnt[gi]),
      .data_addr_i  (addr[gi]),
      .data_we_i    (we[gi]),
      .data_be_i    (be[gi]),
      .data_wdata_i (wdata[gi]),
      .data_rvalid_o(rvalid[gi]),
      .data_rdata_o (rdata[gi]),
      .data_err_o   (err[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one word array per instance and the single in-flight response.
  logic [31:0] mem_m [NI][DEPTH];
  bit          pend  [NI];
  int          due   [NI];
  logic [31:0] exp_rd[NI];
  logic        exp_e [NI];

  int          g_cnt [NI];
  int          rv_cnt[NI];
  int          g_hist[NI][16];
  int          rv_hist_cyc[NI][16];
  logic [31:0] rv_hist_rd [NI][16];
  logic        rv_hist_err[NI][16];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    for (int k = 0; k < NI; k++) begin
      logic eg, ev, e;
      int   wi;
      eg = req[k] && !rst[k] && !pend[k];
      ev = pend[k] && (cyc == due[k]);
      chk("gnt",    k, 32'(gnt[k]),    32'(eg));
      chk("rvalid", k, 32'(rvalid[k]), 32'(ev));
      chk("rdata",  k, rdata[k],       ev ? exp_rd[k] : 32'h0);
      chk("err",    k, 32'(err[k]),    ev ? 32'(exp_e[k]) : 32'h0);
      if (gnt[k]) begin
        g_hist[k][g_cnt[k] % 16] = cyc;
        g_cnt[k]++;
      end
      if (rvalid[k]) begin
        rv_hist_cyc[k][rv_cnt[k] % 16] = cyc;
        rv_hist_rd [k][rv_cnt[k] % 16] = rdata[k];
        rv_hist_err[k][rv_cnt[k] % 16] = err[k];
        rv_cnt[k]++;
      end
      if (rst[k]) begin
        pend[k] = 1'b0;
      end else begin
        if (ev) pend[k] = 1'b0;
        if (eg) begin
          e  = (addr[k][1:0] != 2'b00) || (addr[k] >= 32'(DEPTH * 4));
          wi = int'(addr[k] >> 2);
          exp_e[k]  = e;
          exp_rd[k] = 32'h0;
          if (!e) begin
            if (we[k]) begin
              for (int l = 0; l < 4; l++)
                if (be[k][l]) mem_m[k][wi][8*l +: 8] = wdata[k][8*l +: 8];
            end else begin
              exp_rd[k] = mem_m[k][wi];
            end
          end
          pend[k] = 1'b1;
          due[k]  = cyc + lat_of(k);
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned s;
    s = $urandom_range(0, 9);
    if (s < 6)  return 32'($urandom_range(0, 15)) << 2;
    if (s == 6) return 32'((DEPTH - 1) * 4);
    if (s == 7) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    if (s == 8) return 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
    return $urandom | 32'h8000_0000;
  endfunction

  task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat_seen, output int gnt_delay);
    int g0, r0, t_req, gc, n;
    g0 = g_cnt[k];
    r0 = rv_cnt[k];
    rd = 32'h0; e = 1'b0; lat_seen = -1; gnt_delay = -1;
    @(posedge clk); #1;
    t_req = cyc;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    n = 0;
    while (g_cnt[k] == g0 && n < 40) begin @(posedge clk); n++; end
    #1;
    req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; be[k] = 4'($urandom); wdata[k] = $urandom;
    if (g_cnt[k] == g0) begin
      chk("gnt_timeout", k, 32'h0, 32'h1);
      return;
    end
    n = 0;
    while (rv_cnt[k] == r0 && n < 40) begin @(posedge clk); n++; end
    if (rv_cnt[k] == r0) begin
      chk("rvalid_timeout", k, 32'h0, 32'h1);
      return;
    end
    gc        = g_hist[k][g0 % 16];
    rd        = rv_hist_rd [k][r0 % 16];
    e         = rv_hist_err[k][r0 % 16];
    lat_seen  = rv_hist_cyc[k][r0 % 16] - gc;
    gnt_delay = gc - t_req;
    $display("txn inst%0d we=%0d addr=%h be=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             k, w, a, b, d, rd, e, lat_seen);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, gd, g0, r0, n;

    rst = '1; req = '1; we = '0; addr = '0; be = '0; wdata = '0;
    for (int k = 0; k < NI; k++) begin
      pend[k] = 1'b0; due[k] = 0; exp_rd[k] = 32'h0; exp_e[k] = 1'b0;
      g_cnt[k] = 0; rv_cnt[k] = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 32'h0;
    end

    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); model_cycle(); end
    join_none

    // Reset held with req high: no grant, response fields quiet.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_gnt",    k, 32'(gnt[k]),    32'h0);
      chk("reset_rvalid", k, 32'(rvalid[k]), 32'h0);
      chk("reset_rdata",  k, rdata[k],       32'h0);
      chk("reset_err",    k, 32'(err[k]),    32'h0);
    end
    @(posedge clk); #1;
    rst = '0; req = '0;

    // Give every word the random phase can load a known value.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) do_txn(k, 1'b1, 32'(i * 4), 4'hF, $urandom, rd, e, lat, gd);
      do_txn(k, 1'b1, 32'((DEPTH - 1) * 4), 4'hF, 32'hDEAD_BEEF, rd, e, lat, gd);
    end

    // Latency 1: store then load.
    do_txn(0, 1'b1, 32'h0, 4'hF, 32'h0000_0001, rd, e, lat, gd);
    chk("st_gnt_same_cycle", 0, 32'(gd), 32'h0);
    chk("st_latency",        0, 32'(lat), 32'h1);
    chk("st_err",            0, 32'(e), 32'h0);
    chk("st_rdata_zero",     0, rd, 32'h0);
    do_txn(0, 1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat, gd);
    chk("ld_rdata",   0, rd, 32'h0000_0001);
    chk("ld_latency", 0, 32'(lat), 32'h1);

    // Byte enables.
    do_txn(0, 1'b1, 32'h10, 4'hF,    32'hAABB_CCDD, rd, e, lat, gd);
    do_txn(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, rd, e, lat, gd);
    do_txn(0, 1'b0, 32'h10, 4'h3,    32'h0, rd, e, lat, gd);
    chk("be_merge", 0, rd, 32'hAA22_CC44);

    // Errors: misaligned store writes nothing, out-of-range load returns zero.
    do_txn(0, 1'b1, 32'h2, 4'hF, 32'hFFFF_FFFF, rd, e, lat, gd);
    chk("misalign_err", 0, 32'(e), 32'h1);
    do_txn(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, e, lat, gd);
    chk("misalign_nowrite", 0, rd, 32'h0000_0001);
    do_txn(0, 1'b0, 32'(DEPTH * 4), 4'hF, 32'h0, rd, e, lat, gd);
    chk("oor_err",   0, 32'(e), 32'h1);
    chk("oor_rdata", 0, rd, 32'h0);
    do_txn(0, 1'b0, 32'((DEPTH - 1) * 4), 4'hF, 32'h0, rd, e, lat, gd);
    chk("last_word_err",   0, 32'(e), 32'h0);
    chk("last_word_rdata", 0, rd, 32'hDEAD_BEEF);

    // Zero-byte store.
    do_txn(0, 1'b1, 32'h4, 4'hF,    32'h1234_5678, rd, e, lat, gd);
    do_txn(0, 1'b1, 32'h4, 4'b0000, 32'hFFFF_FFFF, rd, e, lat, gd);
    chk("be0_err", 0, 32'(e), 32'h0);
    do_txn(0, 1'b0, 32'h4, 4'hF, 32'h0, rd, e, lat, gd);
    chk("be0_keep", 0, rd, 32'h1234_5678);

    // Latency 3, req held high across two loads.
    do_txn(1, 1'b1, 32'h10, 4'hF, 32'hCAFE_0001, rd, e, lat, gd);
    chk("lat3_store", 1, 32'(lat), 32'h3);
    g0 = g_cnt[1];
    r0 = rv_cnt[1];
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; be[1] = 4'h0;
    n = 0;
    while (rv_cnt[1] < r0 + 2 && n < 40) begin @(posedge clk); n++; end
    #1;
    req[1] = 1'b0;
    chk("b2b_rv_count",  1, 32'(rv_cnt[1] - r0), 32'h2);
    chk("b2b_gnt_count", 1, 32'(g_cnt[1] - g0),  32'h2);
    chk("b2b_gnt_gap",   1, 32'(g_hist[1][(g0 + 1) % 16] - g_hist[1][g0 % 16]), 32'h4);
    chk("b2b_rv0_cyc",   1, 32'(rv_hist_cyc[1][r0 % 16] - g_hist[1][g0 % 16]), 32'h3);
    chk("b2b_rv1_cyc",   1, 32'(rv_hist_cyc[1][(r0 + 1) % 16] - g_hist[1][g0 % 16]), 32'h7);
    chk("b2b_rd0",       1, rv_hist_rd[1][r0 % 16], 32'hCAFE_0001);
    chk("b2b_rd1",       1, rv_hist_rd[1][(r0 + 1) % 16], 32'hCAFE_0001);
    $display("txn inst1 back-to-back loads addr=00000010 grants=%0d rvalids=%0d",
             g_cnt[1] - g0, rv_cnt[1] - r0);

    // Latency 4: reset two cycles after a granted store.
    g0 = g_cnt[2];
    r0 = rv_cnt[2];
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; be[2] = 4'hF; wdata[2] = 32'h5555_5555;
    n = 0;
    while (g_cnt[2] == g0 && n < 40) begin @(posedge clk); n++; end
    #1;
    req[2] = 1'b0;
    chk("rst_store_gnt", 2, 32'(g_cnt[2] - g0), 32'h1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    repeat (8) @(posedge clk);
    chk("rst_drop_rvalid", 2, 32'(rv_cnt[2] - r0), 32'h0);
    $display("txn inst2 store addr=00000008 wdata=55555555 dropped by reset");
    do_txn(2, 1'b0, 32'h8, 4'hF, 32'h0, rd, e, lat, gd);
    chk("rst_store_kept", 2, rd, 32'h5555_5555);
    chk("lat4_load",      2, 32'(lat), 32'h4);

    // Randomized traffic, including reset hits and requests dropped before grant.
    for (int c = 0; c < RAND_CYCLES; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        rst[k]   = ($urandom_range(0, 99) < 2);
        req[k]   = ($urandom_range(0, 99) < 55);
        we[k]    = 1'($urandom);
        addr[k]  = rnd_addr();
        be[k]    = 4'($urandom);
        wdata[k] = $urandom;
      end
    end
    @(posedge clk); #1;
    rst = '0; req = '0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
